// File: rtl/apb_accum_multi.sv
// apb_accum_multi: APB3 slave with NUM_CH independent accumulator channels sharing one
// adder/subtractor. Pending commands are served one per cycle in round-robin order.
//
// Register map per channel (ch = PADDR[ADDR_W-1:4], offset = PADDR[3:0]):
//   0x0 ADDEND  RW  operand, sampled when the command executes
//   0x4 CONTROL RW  full word stored; bits[1:0] 1=ADD 2=CLEAR 3=SUB queue a command
//   0x8 RESULT  RO  accumulator
//   0xC STATUS      bit0 OVF (W1C, sticky), bit1 PENDING (RO)
//
// Ports:
//   PCLK, PRESETn          bus clock, asynchronous active-low reset
//   PSEL, PENABLE, PWRITE  APB control
//   PADDR, PWDATA          byte address, write data
//   PRDATA, PREADY, PSLVERR APB response (PREADY low while a target command is pending)
//   ovf_irq                registered OR of all channel OVF flags
//
// Optional feature: define ACCUM_SATURATE_EN to clamp on overflow/borrow instead of wrapping.

module apb_accum_multi #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned NUM_CH = 4
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [DATA_W-1:0] PWDATA,
  output logic [DATA_W-1:0] PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic              ovf_irq
);

  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [ADDR_W-5:0] NUM_CH_A = (ADDR_W-4)'(NUM_CH);

  // Channel state
  logic [DATA_W-1:0] addend_q  [NUM_CH];
  logic [DATA_W-1:0] control_q [NUM_CH];
  logic [DATA_W-1:0] result_q  [NUM_CH];
  logic [1:0]        cmd_q     [NUM_CH];
  logic [NUM_CH-1:0] pending_q;
  logic [NUM_CH-1:0] ovf_q;
  logic [CH_W-1:0]   rr_ptr_q;
  logic              ovf_irq_q;

  // Address decode
  logic            access;
  logic            ch_ok;
  logic [CH_W-1:0] ch_idx;
  logic [3:0]      off;
  logic            err;
  logic            cmd_wr;
  logic            stall_kind;
  logic            stall;
  logic            done;
  logic            wr_en;
  logic [DATA_W-1:0] rdata;

  assign access = PSEL && PENABLE;
  assign ch_ok  = (PADDR[ADDR_W-1:4] < NUM_CH_A);
  assign ch_idx = ch_ok ? PADDR[4 +: CH_W] : '0;
  assign off    = PADDR[3:0];
  assign err    = !ch_ok || (off[1:0] != 2'b00) || (PWRITE && (off[3:2] == 2'b10));
  assign cmd_wr = PWRITE && (off[3:2] == 2'b01) && (PWDATA[1:0] != 2'b00);

  // RESULT/STATUS reads and command writes must wait for the channel's queued command so
  // reads see its effect and a new command never overwrites an unexecuted one.
  assign stall_kind = (!PWRITE && off[3]) || cmd_wr;
  assign stall      = access && !err && stall_kind && pending_q[ch_idx];
  assign done       = access && !stall;
  assign wr_en      = done && !err && PWRITE;

  always_comb begin
    rdata = '0;
    unique case (off[3:2])
      2'b00: rdata = addend_q[ch_idx];
      2'b01: rdata = control_q[ch_idx];
      2'b10: rdata = result_q[ch_idx];
      2'b11: rdata = {{(DATA_W-2){1'b0}}, pending_q[ch_idx], ovf_q[ch_idx]};
    endcase
  end

  assign PREADY  = !stall;
  assign PSLVERR = access && err;
  assign PRDATA  = (done && !err && !PWRITE) ? rdata : '0;
  assign ovf_irq = ovf_irq_q;

  // Round-robin arbiter: scan downward so the lowest offset from the pointer wins.
  logic            grant_vld;
  logic [CH_W-1:0] grant_ch;
  logic [CH_W-1:0] cand;
  int unsigned     idx;

  always_comb begin
    grant_vld = 1'b0;
    grant_ch  = '0;
    cand      = '0;
    idx       = 0;
    for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
      idx = 32'(rr_ptr_q) + 32'(i);
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      cand = CH_W'(idx);
      if (pending_q[cand]) begin
        grant_vld = 1'b1;
        grant_ch  = cand;
      end
    end
  end

  logic [CH_W-1:0] next_ptr;

  always_comb begin
    if (32'(grant_ch) == NUM_CH - 32'd1) next_ptr = '0;
    else                                 next_ptr = grant_ch + 1'b1;
  end

  // Shared adder/subtractor
  logic [DATA_W:0]   sum_w;
  logic [DATA_W:0]   diff_w;
  logic [DATA_W-1:0] exec_result;
  logic              exec_ovf;

  assign sum_w  = {1'b0, result_q[grant_ch]} + {1'b0, addend_q[grant_ch]};
  assign diff_w = {1'b0, result_q[grant_ch]} - {1'b0, addend_q[grant_ch]};

  always_comb begin
    exec_result = result_q[grant_ch];
    exec_ovf    = 1'b0;
    unique case (cmd_q[grant_ch])
      2'd1: begin
        exec_ovf = sum_w[DATA_W];
`ifdef ACCUM_SATURATE_EN
        exec_result = sum_w[DATA_W] ? '1 : sum_w[DATA_W-1:0];
`else
        exec_result = sum_w[DATA_W-1:0];
`endif
      end
      2'd3: begin
        exec_ovf = diff_w[DATA_W];
`ifdef ACCUM_SATURATE_EN
        exec_result = diff_w[DATA_W] ? '0 : diff_w[DATA_W-1:0];
`else
        exec_result = diff_w[DATA_W-1:0];
`endif
      end
      2'd2:    exec_result = '0;
      default: exec_result = result_q[grant_ch];
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int i = 0; i < int'(NUM_CH); i++) begin
        addend_q[i]  <= '0;
        control_q[i] <= '0;
        result_q[i]  <= '0;
        cmd_q[i]     <= '0;
      end
      pending_q <= '0;
      ovf_q     <= '0;
      rr_ptr_q  <= '0;
      ovf_irq_q <= 1'b0;
    end else begin
      ovf_irq_q <= |ovf_q;

      if (grant_vld) begin
        result_q[grant_ch]  <= exec_result;
        pending_q[grant_ch] <= 1'b0;
        rr_ptr_q            <= next_ptr;
      end

      if (wr_en) begin
        case (off[3:2])
          2'b00: addend_q[ch_idx] <= PWDATA;
          2'b01: begin
            control_q[ch_idx] <= PWDATA;
            if (cmd_wr) begin
              cmd_q[ch_idx]     <= PWDATA[1:0];
              pending_q[ch_idx] <= 1'b1;
            end
          end
          2'b11: if (PWDATA[0]) ovf_q[ch_idx] <= 1'b0;
          default: ;
        endcase
      end

      // Placed after the W1C so a simultaneous overflow wins.
      if (grant_vld && exec_ovf) ovf_q[grant_ch] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_apb_accum_multi.sv
module tb_apb_accum_multi;

  localparam int unsigned NCH = 4;

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic        PSEL = 1'b0;
  logic        PENABLE = 1'b0;
  logic        PWRITE = 1'b0;
  logic [31:0] PADDR = '0;
  logic [31:0] PWDATA = '0;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic        ovf_irq;

  int tests = 0;
  int fails = 0;

  logic [31:0] exp_q[$];

  // Reference model
  logic [31:0] m_res[NCH];
  logic [31:0] m_add[NCH];
  logic [31:0] m_ctl[NCH];
  logic        m_ovf[NCH];

  apb_accum_multi #(
    .DATA_W(32),
    .ADDR_W(32),
    .NUM_CH(NCH)
  ) dut (
    .PCLK   (PCLK),
    .PRESETn(PRESETn),
    .PSEL   (PSEL),
    .PENABLE(PENABLE),
    .PWRITE (PWRITE),
    .PADDR  (PADDR),
    .PWDATA (PWDATA),
    .PRDATA (PRDATA),
    .PREADY (PREADY),
    .PSLVERR(PSLVERR),
    .ovf_irq(ovf_irq)
  );

  always #5 PCLK = ~PCLK;

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic model_reset;
    for (int c = 0; c < NCH; c++) begin
      m_res[c] = '0; m_add[c] = '0; m_ctl[c] = '0; m_ovf[c] = 1'b0;
    end
  endtask

  task automatic model_exec(input int c, input logic [1:0] code);
    logic [32:0] t;
    case (code)
      2'd1: begin
        t = {1'b0, m_res[c]} + {1'b0, m_add[c]};
        if (t[32]) m_ovf[c] = 1'b1;
`ifdef ACCUM_SATURATE_EN
        m_res[c] = t[32] ? 32'hFFFF_FFFF : t[31:0];
`else
        m_res[c] = t[31:0];
`endif
      end
      2'd3: begin
        t = {1'b0, m_res[c]} - {1'b0, m_add[c]};
        if (t[32]) m_ovf[c] = 1'b1;
`ifdef ACCUM_SATURATE_EN
        m_res[c] = t[32] ? 32'h0 : t[31:0];
`else
        m_res[c] = t[31:0];
`endif
      end
      2'd2: m_res[c] = '0;
      default: ;
    endcase
  endtask

  // One complete APB transfer; a transfer that never completes counts as a failure.
  task automatic apb(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                     output logic [31:0] rdata, output logic err, output int waits);
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
    @(negedge PCLK);
    PENABLE = 1'b1;
    #1;
    waits = 0;
    while (PREADY !== 1'b1 && waits < 40) begin
      @(negedge PCLK); #1;
      waits++;
    end
    if (PREADY !== 1'b1) begin
      tests++; fails++;
      $display("FAIL xfer_timeout addr=%h waits=%0d", addr, waits);
    end
    rdata = PRDATA;
    err   = PSLVERR;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic set_add(input int c, input logic [31:0] v);
    logic [31:0] d; logic e; int w;
    apb(1'b1, 32'(c * 16), v, d, e, w);
    m_add[c] = v;
  endtask

  task automatic do_cmd(input int c, input logic [31:0] v);
    logic [31:0] d; logic e; int w;
    apb(1'b1, 32'(c * 16 + 4), v, d, e, w);
    m_ctl[c] = v;
    model_exec(c, v[1:0]);
  endtask

  task automatic test_reset;
    logic [31:0] d, e; logic err; int w;
    int chs[2];
    PRESETn = 1'b0;
    model_reset();
    repeat (3) @(negedge PCLK);
    PRESETn = 1'b1;
    #1;
    tests++;
    if ({PRDATA, PREADY, PSLVERR, ovf_irq} !== {32'h0, 1'b1, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL reset_idle got prdata=%h ready=%b slverr=%b irq=%b want 0/1/0/0",
               PRDATA, PREADY, PSLVERR, ovf_irq);
    end
    chs[0] = 0; chs[1] = NCH - 1;
    for (int k = 0; k < 2; k++) begin
      for (int o = 0; o < 4; o++) begin
        exp_q.push_back(32'h0);
        apb(1'b0, 32'(chs[k] * 16 + o * 4), 32'h0, d, err, w);
        e = exp_q.pop_front();
        tests++;
        if (d !== e || err !== 1'b0) begin
          fails++;
          $display("FAIL reset_read ch%0d off%0h got=%h err=%b want=%h err=0",
                   chs[k], o * 4, d, err, e);
        end
      end
    end
  endtask

  task automatic test_accum;
    logic [31:0] d, e; logic err; int w;
    set_add(1, 32'd10); do_cmd(1, 32'd1);
    set_add(1, 32'd5);  do_cmd(1, 32'd1);
    exp_q.push_back(m_res[1]);
    apb(1'b0, 32'h18, 32'h0, d, err, w);
    e = exp_q.pop_front();
    tests++;
    if (d !== e || e !== 32'd15) begin
      fails++; $display("FAIL accum_add got=%h want=%h", d, 32'd15);
    end
    exp_q.push_back(m_res[0]);
    apb(1'b0, 32'h08, 32'h0, d, err, w);
    e = exp_q.pop_front();
    tests++;
    if (d !== e) begin fails++; $display("FAIL isolation_ch0 got=%h want=%h", d, e); end
    set_add(1, 32'd4); do_cmd(1, 32'd3);
    exp_q.push_back(m_res[1]);
    apb(1'b0, 32'h18, 32'h0, d, err, w);
    e = exp_q.pop_front();
    tests++;
    if (d !== e || e !== 32'd11) begin
      fails++; $display("FAIL accum_sub got=%h want=%h", d, 32'd11);
    end
    do_cmd(1, 32'd2);
    exp_q.push_back(m_res[1]);
    exp_q.push_back(m_ctl[1]);
    apb(1'b0, 32'h18, 32'h0, d, err, w);
    e = exp_q.pop_front();
    tests++;
    if (d !== e) begin fails++; $display("FAIL accum_clear got=%h want=%h", d, e); end
    apb(1'b0, 32'h14, 32'h0, d, err, w);
    e = exp_q.pop_front();
    tests++;
    if (d !== e || e !== 32'd2) begin fails++; $display("FAIL ctl_readback got=%h want=2", d); end
    // Unused high bits with code 0: stored, no command queued
    do_cmd(1, 32'hABCD_0000);
    exp_q.push_back({30'h0, 1'b0, m_ovf[1]});
    apb(1'b0, 32'h1C, 32'h0, d, err, w);
    e = exp_q.pop_front();
    tests++;
    if (d !== e) begin fails++; $display("FAIL status_noop got=%h want=%h", d, e); end
  endtask

  task automatic test_overflow;
    logic [31:0] d, e; logic err; int w;
    set_add(2, 32'hFFFF_FFFF); do_cmd(2, 32'd1);
    set_add(2, 32'd2);         do_cmd(2, 32'd1);
    exp_q.push_back(m_res[2]);
    exp_q.push_back({30'h0, 1'b0, m_ovf[2]});
    apb(1'b0, 32'h28, 32'h0, d, err, w);
    e = exp_q.pop_front();
    tests++;
    if (d !== e) begin fails++; $display("FAIL ovf_result got=%h want=%h", d, e); end
    apb(1'b0, 32'h2C, 32'h0, d, err, w);
    e = exp_q.pop_front();
    tests++;
    if (d !== e || e !== 32'h1) begin fails++; $display("FAIL ovf_status got=%h want=1", d); end
    tests++;
    if (ovf_irq !== 1'b1) begin fails++; $display("FAIL ovf_irq_set got=%b want=1", ovf_irq); end
    apb(1'b1, 32'h2C, 32'h1, d, err, w);
    m_ovf[2] = 1'b0;
    @(negedge PCLK);
    tests++;
    if (ovf_irq !== 1'b1) begin fails++; $display("FAIL ovf_irq_lag got=%b want=1", ovf_irq); end
    @(negedge PCLK);
    tests++;
    if (ovf_irq !== 1'b0) begin fails++; $display("FAIL ovf_irq_clr got=%b want=0", ovf_irq); end
    exp_q.push_back({30'h0, 1'b0, m_ovf[2]});
    apb(1'b0, 32'h2C, 32'h0, d, err, w);
    e = exp_q.pop_front();
    tests++;
    if (d !== e) begin fails++; $display("FAIL w1c_status got=%h want=%h", d, e); end
    // Subtract 3 from the current value; borrows in wrap mode, not in saturate mode
    set_add(2, 32'd3); do_cmd(2, 32'd3);
    exp_q.push_back(m_res[2]);
    exp_q.push_back({30'h0, 1'b0, m_ovf[2]});
    apb(1'b0, 32'h28, 32'h0, d, err, w);
    e = exp_q.pop_front();
    tests++;
    if (d !== e) begin fails++; $display("FAIL sub_result got=%h want=%h", d, e); end
    apb(1'b0, 32'h2C, 32'h0, d, err, w);
    e = exp_q.pop_front();
    tests++;
    if (d !== e) begin fails++; $display("FAIL sub_status got=%h want=%h", d, e); end
    apb(1'b1, 32'h2C, 32'h1, d, err, w);
    m_ovf[2] = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [31:0] d, e; logic err; int w;
    for (int c = 0; c < NCH; c++) set_add(c, 32'(100 + c));
    for (int c = 0; c < NCH; c++) begin
      m_ctl[c] = 32'd1;
      model_exec(c, 2'd1);
    end
    exp_q.push_back(m_res[NCH-1]);
    // Access phases issued without setup cycles in between so the last command is still
    // queued when the RESULT read arrives.
    @(negedge PCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h04; PWDATA = 32'd1;
    for (int c = 0; c < NCH; c++) begin
      @(negedge PCLK);
      PENABLE = 1'b1; PADDR = 32'(c * 16 + 4);
      #1;
      tests++;
      if (PREADY !== 1'b1) begin fails++; $display("FAIL burst_wr_ready ch%0d got=%b", c, PREADY); end
    end
    @(negedge PCLK);
    PWRITE = 1'b0; PADDR = 32'((NCH - 1) * 16 + 8);
    #1;
    w = 0;
    while (PREADY !== 1'b1 && w < 40) begin
      @(negedge PCLK); #1;
      w++;
    end
    d = PRDATA;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    e = exp_q.pop_front();
    tests++;
    if (w < 1 || w >= 40) begin fails++; $display("FAIL stall_waits got=%0d want>=1", w); end
    tests++;
    if (d !== e) begin fails++; $display("FAIL stall_result got=%h want=%h", d, e); end
    for (int c = 0; c < NCH; c++) begin
      exp_q.push_back(m_res[c]);
      apb(1'b0, 32'(c * 16 + 8), 32'h0, d, err, w);
      e = exp_q.pop_front();
      tests++;
      if (d !== e) begin fails++; $display("FAIL rr_result ch%0d got=%h want=%h", c, d, e); end
    end
  endtask

  task automatic test_errors;
    logic [31:0] d, e; logic err; int w;
    apb(1'b1, 32'h08, 32'hDEAD_BEEF, d, err, w);
    tests++;
    if (err !== 1'b1 || w != 0) begin
      fails++; $display("FAIL err_wr_result got err=%b waits=%0d want err=1 waits=0", err, w);
    end
    exp_q.push_back(m_res[0]);
    apb(1'b0, 32'h08, 32'h0, d, err, w);
    e = exp_q.pop_front();
    tests++;
    if (d !== e || err !== 1'b0) begin fails++; $display("FAIL result_kept got=%h want=%h", d, e); end
    apb(1'b0, 32'h1000_0000, 32'h0, d, err, w);
    tests++;
    if (err !== 1'b1 || d !== 32'h0) begin
      fails++; $display("FAIL err_hi_ch got err=%b data=%h want err=1 data=0", err, d);
    end
    apb(1'b0, 32'h40, 32'h0, d, err, w);
    tests++;
    if (err !== 1'b1 || d !== 32'h0) begin
      fails++; $display("FAIL err_ch4 got err=%b data=%h want err=1 data=0", err, d);
    end
    apb(1'b1, 32'h02, 32'h1234_5678, d, err, w);
    tests++;
    if (err !== 1'b1) begin fails++; $display("FAIL err_misalign got err=%b want 1", err); end
    exp_q.push_back(m_add[0]);
    apb(1'b0, 32'h00, 32'h0, d, err, w);
    e = exp_q.pop_front();
    tests++;
    if (d !== e) begin fails++; $display("FAIL addend_kept got=%h want=%h", d, e); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] d, e; logic err; int w;
    set_add(1, 32'd7);
    apb(1'b1, 32'h14, 32'd1, d, err, w);
    // Reset pulse lands between edges while the ADD is still queued
    #2 PRESETn = 1'b0;
    #3 PRESETn = 1'b1;
    model_reset();
    for (int o = 0; o < 4; o++) begin
      exp_q.push_back(32'h0);
      apb(1'b0, 32'(16 + o * 4), 32'h0, d, err, w);
      e = exp_q.pop_front();
      tests++;
      if (d !== e || err !== 1'b0 || w != 0) begin
        fails++;
        $display("FAIL reset_mid off%0h got=%h err=%b waits=%0d want=%h", o * 4, d, err, w, e);
      end
    end
    repeat (3) @(negedge PCLK);
    exp_q.push_back(32'h0);
    apb(1'b0, 32'h18, 32'h0, d, err, w);
    e = exp_q.pop_front();
    tests++;
    if (d !== e || ovf_irq !== 1'b0) begin
      fails++; $display("FAIL reset_mid_late got=%h irq=%b want=%h irq=0", d, ovf_irq, e);
    end
  endtask

  initial begin
    test_reset();
    test_accum();
    test_overflow();
    test_back_to_back();
    test_errors();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/apb_accum_multi.md
Name: apb_accum_multi

Overview:
- APB3 slave with NUM_CH independent accumulator channels. Each channel has an ADDEND register, a CONTROL register, a read-only RESULT register and a STATUS register.
- One shared adder/subtractor serves commands that are waiting to run, picking channels in round-robin order.
- PREADY wait states keep RESULT reads coherent and prevent a second command from overwriting one that has not run yet.
- Sits on the peripheral APB bus in place of the single-channel accumulator.

Parameters:
- DATA_W, 32, width of PWDATA/PRDATA and of every channel register.
- ADDR_W, 32, width of PADDR.
- NUM_CH, 4, number of channels, 1..16.

Ports:
- PCLK  in  1  bus clock; all state changes on its rising edge.
- PRESETn  in  1  reset, asynchronous, active-low.
- PSEL  in  1  slave select.
- PENABLE  in  1  access phase.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  ADDR_W  byte address.
- PWDATA  in  DATA_W  write data.
- PRDATA  out  DATA_W  read data; valid in the completing access cycle.
- PREADY  out  1  transfer completes when high in the access phase.
- PSLVERR  out  1  error response; valid in the completing access cycle.
- ovf_irq  out  1  OR of all channel OVF flags, registered.

Behaviour:
- Reset (PRESETn low, asynchronous):
  - Every ADDEND, CONTROL, RESULT, OVF and pending flag = 0; round-robin pointer = 0.
  - PRDATA = 0, PREADY = 1, PSLVERR = 0, ovf_irq = 0.
  - A transfer in flight is abandoned; pending commands are dropped.
- Address decode:
  - ch = PADDR[ADDR_W-1:4]; offset = PADDR[3:0].
  - Offsets: 0x0 ADDEND (RW), 0x4 CONTROL (RW), 0x8 RESULT (RO), 0xC STATUS (bit0 OVF W1C, bit1 PENDING RO, other bits read 0).
- Error response (PSLVERR = 1):
  - Raised for ch >= NUM_CH, for PADDR[1:0] != 0, and for a write to RESULT.
  - An errored transfer causes no state change, returns PRDATA = 0 and has no wait states.
- Transfer timing:
  - Setup phase (PSEL=1, PENABLE=0), then access phase (PENABLE=1).
  - The transfer completes in the access cycle with PREADY=1.
  - Writes take effect at the rising edge that ends the completing cycle.
- Commands:
  - A CONTROL write stores the full PWDATA, which reads back unchanged.
  - If PWDATA[1:0] is 1 (ADD), 2 (CLEAR) or 3 (SUB), the write also sets pending[ch].
  - Code 0, or an unused high-bit pattern whose low bits decode to 0, is a stored no-op.
  - The command is captured at the time of the write. ADDEND is sampled when the command executes, not when it was written.
- Execution:
  - Each cycle the arbiter picks the first pending channel at or after the round-robin pointer, wrapping.
  - It runs that channel's command, clears its pending flag and sets the pointer to (ch+1) mod NUM_CH.
  - One command per cycle; latency from the write's completing edge to the RESULT update is 1..NUM_CH cycles.
- Arithmetic (unsigned, DATA_W wide):
  - ADD: RESULT + ADDEND, wraps modulo 2^DATA_W; carry-out sets OVF.
  - SUB: RESULT - ADDEND, wraps; a borrow sets OVF.
  - CLEAR: RESULT = 0; OVF unchanged.
- Wait states:
  - A read of RESULT or STATUS, or a command-bearing CONTROL write, to a channel whose pending flag is set holds PREADY = 0 until that flag clears. The maximum stall is NUM_CH cycles.
  - ADDEND accesses never stall.
  - A non-stalling access phase has PREADY = 1 with zero wait states.
- OVF flags:
  - OVF is sticky and cleared by writing 1 to STATUS bit0.
  - If a W1C and an overflow land on the same edge, set wins.
  - ovf_irq follows the OR of the OVF flags, one cycle later.
- Mid-transfer abort: if PSEL drops mid-transfer, the slave returns to idle with no state change.

Optional Feature:
- Macro: ACCUM_SATURATE_EN.
- When defined:
  - An ADD overflow clamps RESULT to 2^DATA_W-1.
  - A SUB borrow clamps RESULT to 0.
  - OVF is still set in both cases.
- When undefined: wrap-around arithmetic exactly as in Behaviour.

Test Plan:
- Reset: after reset, read 0x00/0x04/0x08/0x0C on channel 0 and on channel NUM_CH-1 -> all return 0, PSLVERR=0, ovf_irq=0.
- Accumulate and isolation:
  - Channel 1: ADDEND=10, CONTROL=1; ADDEND=5, CONTROL=1; read 0x18 -> 15.
  - Channel 0 RESULT stays 0.
  - CONTROL=3 with ADDEND=4 -> 11.
  - CONTROL=2 -> 0; CONTROL reads back 2.
- Overflow:
  - Channel 2 ADDEND=0xFFFFFFFF ADD, then ADDEND=2 ADD -> RESULT=1 (wrap) or 0xFFFFFFFF (ACCUM_SATURATE_EN).
  - STATUS=0x1 and ovf_irq=1.
  - W1C 0x1 -> STATUS=0, ovf_irq=0 next cycle.
- Arbitration and stall:
  - Issue ADD to channels 0..3 back-to-back, then read channel 3 RESULT immediately -> PREADY low for at least 1 cycle, returned value includes the addend.
  - All four results correct, no command lost.
- Errors:
  - Write 0x08 = 0xDEADBEEF -> PSLVERR=1, RESULT unchanged.
  - Read 0x10000000 and 0x40 (NUM_CH=4) -> PSLVERR=1, PRDATA=0.
  - Write 0x02 -> PSLVERR=1.
- Reset mid-operation: ADD pending on channel 1 with PRESETn pulsed low for 3 ns between edges -> all registers 0, the pending command never executes, the next transfer completes normally.
